// File: rtl/keypad_scan_display.sv
// 4x4 hex keypad scanner with tick-based debounce, NDIGITS-deep key history and
// multiplexed common-anode seven-segment drive. Define KEYPAD_BLANK_EN to blank never-written digits.
module keypad_scan_display #(
  parameter int TIMEBITS = 3,
  parameter int DEBOUNCE = 2,
  parameter int NDIGITS  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             rows,
  output logic [3:0]             cols,
  output logic                   key_valid,
  output logic [3:0]             key_code,
  output logic [4*NDIGITS-1:0]   digits,
  output logic [NDIGITS-1:0]     en,
  output logic [6:0]             seg,
  output logic [1:0]             scan_state
);

  localparam int SEL_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [NDIGITS-1:0] EN_ONE = NDIGITS'(1);

  // Handshake: key_valid is a one-cycle strobe with no ready; key_code and digits
  // are already updated in the same cycle the strobe is high and hold afterwards.

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  state_t              state;
  logic [3:0]          rows_m;
  logic [3:0]          rows_s;
  logic [TIMEBITS-1:0] tick_cnt;
  logic                tick;
  logic [1:0]          col_idx;
  logic [1:0]          key_row;
  logic [CNT_W-1:0]    cnt;
  logic [SEL_W-1:0]    digit_sel;
  logic [3:0]          new_code;
  logic [4*NDIGITS+3:0] digits_shifted;
  logic [3:0]          cur_nibble;
  logic [6:0]          cur_seg;

  function automatic logic [1:0] top_row(input logic [3:0] r);
    if (r[3])      return 2'd3;
    else if (r[2]) return 2'd2;
    else if (r[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  // Index is {column, row}; row 3 is the top row of the keypad.
  function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] code;
    case ({c, r})
      4'b00_11: code = 4'h1;  4'b00_10: code = 4'h4;
      4'b00_01: code = 4'h7;  4'b00_00: code = 4'hE;
      4'b01_11: code = 4'h2;  4'b01_10: code = 4'h5;
      4'b01_01: code = 4'h8;  4'b01_00: code = 4'h0;
      4'b10_11: code = 4'h3;  4'b10_10: code = 4'h6;
      4'b10_01: code = 4'h9;  4'b10_00: code = 4'hF;
      4'b11_11: code = 4'hA;  4'b11_10: code = 4'hB;
      4'b11_01: code = 4'hC;  default:  code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0011000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b0100111;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick           = &tick_cnt;
  assign cols           = 4'b1000 >> col_idx;
  assign new_code       = key_map(col_idx, key_row);
  assign digits_shifted = {digits, new_code};
  assign scan_state     = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rows_m   <= 4'b0;
      rows_s   <= 4'b0;
      tick_cnt <= '0;
    end else begin
      rows_m   <= rows;
      rows_s   <= rows_m;
      tick_cnt <= tick_cnt + TIMEBITS'(1);
    end
  end

  // Column stays frozen from detection until the latched row releases.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_SCAN;
      col_idx   <= 2'd0;
      key_row   <= 2'd0;
      cnt       <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      digits    <= '0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        unique case (state)
          ST_SCAN: begin
            if (rows_s == 4'b0) begin
              col_idx <= col_idx + 2'd1;
            end else begin
              key_row <= top_row(rows_s);
              cnt     <= '0;
              state   <= ST_DEBOUNCE;
            end
          end
          ST_DEBOUNCE: begin
            if (!rows_s[key_row]) begin
              state <= ST_SCAN;
            end else if (cnt == CNT_W'(DEBOUNCE - 1)) begin
              key_valid <= 1'b1;
              key_code  <= new_code;
              digits    <= digits_shifted[4*NDIGITS-1:0];
              state     <= ST_HELD;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_HELD: begin
            if (!rows_s[key_row]) begin
              col_idx <= col_idx + 2'd1;
              state   <= ST_SCAN;
            end
          end
          default: state <= ST_SCAN;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      digit_sel <= '0;
    end else if (tick) begin
      if (digit_sel == SEL_W'(NDIGITS - 1)) digit_sel <= '0;
      else                                  digit_sel <= digit_sel + SEL_W'(1);
    end
  end

  assign en         = EN_ONE << digit_sel;
  assign cur_nibble = digits[{digit_sel, 2'b00} +: 4];
  assign cur_seg    = decode(cur_nibble);

`ifdef KEYPAD_BLANK_EN
  logic [NDIGITS-1:0] dvalid;
  logic [NDIGITS:0]   dvalid_shifted;

  assign dvalid_shifted = {dvalid, 1'b1};

  // Valid bits shift in lockstep with the digit history.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dvalid <= '0;
    end else if (tick && state == ST_DEBOUNCE && rows_s[key_row] &&
                 cnt == CNT_W'(DEBOUNCE - 1)) begin
      dvalid <= dvalid_shifted[NDIGITS-1:0];
    end
  end

  assign seg = dvalid[digit_sel] ? cur_seg : 7'b1111111;
`else
  assign seg = cur_seg;
`endif

endmodule
